// File: rtl/sargantana_icache_mem_ctrl.sv
// Sequencing controller for the icache tag/data memory pair:
// lookups, refills, flush sweeps and per-way hit evaluation.
module sargantana_icache_mem_ctrl #(
  parameter int ICACHE_N_WAY = 4,
  parameter int ICACHE_DEPTH = 64,
  parameter int ADDR_WIDHT   = 6,
  parameter int TAG_WIDHT    = 20,
  parameter int WAY_WIDHT    = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              lookup_valid_i,
  output logic                              lookup_ready_o,
  input  logic [ADDR_WIDHT-1:0]             lookup_addr_i,
  input  logic [TAG_WIDHT-1:0]              lookup_tag_i,
  output logic                              rsp_valid_o,
  output logic                              rsp_hit_o,
  output logic [ICACHE_N_WAY-1:0]           rsp_hit_way_o,
  input  logic                              refill_valid_i,
  output logic                              refill_ready_o,
  input  logic [ADDR_WIDHT-1:0]             refill_addr_i,
  input  logic [TAG_WIDHT-1:0]              refill_tag_i,
  input  logic [WAY_WIDHT-1:0]              refill_cline_i,
  output logic [ICACHE_N_WAY-1:0]           refill_way_o,
  input  logic                              flush_req_i,
  output logic                              flush_busy_o,
  output logic                              flush_done_o,
  output logic [ICACHE_N_WAY-1:0]           tag_req_o,
  output logic [ICACHE_N_WAY-1:0]           data_req_o,
  output logic                              tag_we_o,
  output logic                              data_we_o,
  output logic                              flush_en_o,
  output logic                              valid_bit_o,
  output logic [TAG_WIDHT-1:0]              tag_o,
  output logic [WAY_WIDHT-1:0]              cline_o,
  output logic [ADDR_WIDHT-1:0]             addr_o,
  input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]           valid_bit_i
);

  localparam int RRW = $clog2(ICACHE_N_WAY);

  typedef enum logic [1:0] {
    RESET_FLUSH,
    IDLE,
    FLUSH
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDHT-1:0]  r_cnt;
  logic [RRW-1:0]         r_rr;
  logic                   r_rsp_valid;
  logic [TAG_WIDHT-1:0]   r_tag;
  logic                   w_sweep;
  logic                   w_last;
  logic                   w_lookup_fire;
  logic                   w_refill_fire;
  logic [ICACHE_N_WAY-1:0] w_hit_way;

  assign w_sweep = (r_state != IDLE);
  assign w_last  = (r_cnt == ADDR_WIDHT'(ICACHE_DEPTH-1));

  assign refill_way_o = ICACHE_N_WAY'(1) << r_rr;
  assign flush_busy_o = w_sweep;

  always_comb begin
    w_next         = r_state;
    lookup_ready_o = 1'b0;
    refill_ready_o = 1'b0;
    flush_done_o   = 1'b0;
    tag_req_o      = '0;
    data_req_o     = '0;
    tag_we_o       = 1'b0;
    data_we_o      = 1'b0;
    flush_en_o     = 1'b0;
    valid_bit_o    = 1'b0;
    tag_o          = '0;
    cline_o        = '0;
    addr_o         = '0;
    w_lookup_fire  = 1'b0;
    w_refill_fire  = 1'b0;
    if (!rst_i) begin
      unique case (r_state)
        RESET_FLUSH, FLUSH: begin
          tag_req_o  = '1;
          tag_we_o   = 1'b1;
          flush_en_o = 1'b1;
          addr_o     = r_cnt;
          if (w_last) begin
            flush_done_o = 1'b1;
            w_next       = IDLE;
          end
        end
        IDLE: begin
          if (flush_req_i) begin
            w_next = FLUSH;
          end else if (refill_valid_i) begin
            refill_ready_o = 1'b1;
            w_refill_fire  = 1'b1;
            tag_req_o      = refill_way_o;
            data_req_o     = refill_way_o;
            tag_we_o       = 1'b1;
            data_we_o      = 1'b1;
            valid_bit_o    = 1'b1;
            addr_o         = refill_addr_i;
            tag_o          = refill_tag_i;
            cline_o        = refill_cline_i;
          end else if (lookup_valid_i) begin
            lookup_ready_o = 1'b1;
            w_lookup_fire  = 1'b1;
            tag_req_o      = '1;
            data_req_o     = '1;
            addr_o         = lookup_addr_i;
          end
        end
        default: w_next = RESET_FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RESET_FLUSH;
      r_cnt       <= '0;
      r_rr        <= '0;
      r_rsp_valid <= 1'b0;
      r_tag       <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= w_lookup_fire;
      if (w_sweep) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_refill_fire) r_rr <= r_rr + 1'b1;
      if (w_lookup_fire) r_tag <= lookup_tag_i;
    end
  end

  // read data belongs to the lookup issued last cycle
  always_comb begin
    w_hit_way = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      w_hit_way[w] = r_rsp_valid & valid_bit_i[w] &
                     (tag_way_i[w*TAG_WIDHT +: TAG_WIDHT] == r_tag);
    end
  end

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_hit_way_o = w_hit_way;
  assign rsp_hit_o     = |w_hit_way;

endmodule

// File: tb/tb_sargantana_icache_mem_ctrl.sv
// Bench for sargantana_icache_mem_ctrl: memory model plus
// set/way scoreboard checked every cycle.
module tb_sargantana_icache_mem_ctrl;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TW = 20;
  localparam int LW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          lookup_valid_i;
  logic          lookup_ready_o;
  logic [AW-1:0] lookup_addr_i;
  logic [TW-1:0] lookup_tag_i;
  logic          rsp_valid_o;
  logic          rsp_hit_o;
  logic [N-1:0]  rsp_hit_way_o;
  logic          refill_valid_i;
  logic          refill_ready_o;
  logic [AW-1:0] refill_addr_i;
  logic [TW-1:0] refill_tag_i;
  logic [LW-1:0] refill_cline_i;
  logic [N-1:0]  refill_way_o;
  logic          flush_req_i;
  logic          flush_busy_o;
  logic          flush_done_o;
  logic [N-1:0]  tag_req_o;
  logic [N-1:0]  data_req_o;
  logic          tag_we_o;
  logic          data_we_o;
  logic          flush_en_o;
  logic          valid_bit_o;
  logic [TW-1:0] tag_o;
  logic [LW-1:0] cline_o;
  logic [AW-1:0] addr_o;
  logic [N*TW-1:0] tag_way_i;
  logic [N-1:0]  valid_bit_i;

  always #5 clk_i = ~clk_i;

  sargantana_icache_mem_ctrl #(
    .ICACHE_N_WAY(N), .ICACHE_DEPTH(D), .ADDR_WIDHT(AW),
    .TAG_WIDHT(TW), .WAY_WIDHT(LW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_addr_i(lookup_addr_i), .lookup_tag_i(lookup_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o),
    .rsp_hit_way_o(rsp_hit_way_o),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
    .refill_addr_i(refill_addr_i), .refill_tag_i(refill_tag_i),
    .refill_cline_i(refill_cline_i), .refill_way_o(refill_way_o),
    .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o),
    .flush_done_o(flush_done_o),
    .tag_req_o(tag_req_o), .data_req_o(data_req_o),
    .tag_we_o(tag_we_o), .data_we_o(data_we_o),
    .flush_en_o(flush_en_o), .valid_bit_o(valid_bit_o),
    .tag_o(tag_o), .cline_o(cline_o), .addr_o(addr_o),
    .tag_way_i(tag_way_i), .valid_bit_i(valid_bit_i)
  );

  // tag/valid memory: synchronous read, write wins over read
  logic [TW-1:0] mem_tag [N][D];
  logic          mem_v   [N][D];
  logic [TW-1:0] rd_tag  [N];
  logic          rd_v    [N];

  always @(posedge clk_i) begin
    for (int w = 0; w < N; w++) begin
      if (tag_req_o[w]) begin
        if (tag_we_o) begin
          mem_tag[w][addr_o] <= tag_o;
          mem_v[w][addr_o]   <= valid_bit_o;
        end else begin
          rd_tag[w] <= mem_tag[w][addr_o];
          rd_v[w]   <= mem_v[w][addr_o];
        end
      end
    end
  end

  always_comb begin
    tag_way_i   = '0;
    valid_bit_i = '0;
    for (int w = 0; w < N; w++) begin
      tag_way_i[w*TW +: TW] = rd_tag[w];
      valid_bit_i[w]        = rd_v[w];
    end
  end

  // scoreboard: what each set/way should hold
  bit      ref_v   [D][N];
  int      ref_tag [D][N];
  int      m_sweep;
  int      m_rr;
  bit      m_pend;
  bit [N-1:0] m_hw;
  int      n_chk = 0;
  int      n_fail = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rs, input bit fl, input bit rv,
                     input int ra, input int rt, input bit lv,
                     input int la, input int lt);
    logic [N-1:0]  e_treq, e_dreq;
    logic          e_twe, e_dwe, e_fen, e_vb, e_lr, e_rr, e_done;
    logic [TW-1:0] e_tag;
    logic [LW-1:0] e_cl;
    logic [AW-1:0] e_addr;
    bit            e_acc, n_pend;
    bit [N-1:0]    n_hw;
    rst_i          = rs;
    flush_req_i    = fl;
    refill_valid_i = rv;
    refill_addr_i  = AW'(ra);
    refill_tag_i   = TW'(rt);
    refill_cline_i = {8{$urandom()}};
    lookup_valid_i = lv;
    lookup_addr_i  = AW'(la);
    lookup_tag_i   = TW'(lt);
    @(negedge clk_i);
    chk("rsp_valid", rsp_valid_o, m_pend);
    chk("rsp_hit_way", rsp_hit_way_o, m_pend ? m_hw : '0);
    chk("rsp_hit", rsp_hit_o, m_pend & (|m_hw));
    e_treq = '0; e_dreq = '0; e_twe = 0; e_dwe = 0; e_fen = 0;
    e_vb = 0; e_lr = 0; e_rr = 0; e_done = 0; e_tag = '0;
    e_cl = '0; e_addr = '0; e_acc = 0; n_pend = 0; n_hw = '0;
    if (rs) begin
      m_sweep = 0;
      m_rr    = 0;
    end else if (m_sweep >= 0) begin
      e_treq = '1; e_twe = 1; e_fen = 1;
      e_addr = AW'(m_sweep); e_acc = 1;
      for (int w = 0; w < N; w++) ref_v[m_sweep][w] = 0;
      if (m_sweep == D-1) begin
        e_done  = 1;
        m_sweep = -1;
      end else begin
        m_sweep++;
      end
    end else if (fl) begin
      m_sweep = 0;
    end else if (rv) begin
      e_rr = 1; e_twe = 1; e_dwe = 1; e_vb = 1;
      e_treq = N'(1) << m_rr; e_dreq = e_treq;
      e_addr = AW'(ra); e_tag = TW'(rt); e_cl = refill_cline_i;
      e_acc = 1;
      ref_v[ra][m_rr]   = 1;
      ref_tag[ra][m_rr] = rt;
      m_rr = (m_rr + 1) % N;
    end else if (lv) begin
      e_lr = 1; e_treq = '1; e_dreq = '1;
      e_addr = AW'(la); e_acc = 1; n_pend = 1;
      for (int w = 0; w < N; w++)
        n_hw[w] = ref_v[la][w] && (ref_tag[la][w] == lt);
    end
    chk("tag_req", tag_req_o, e_treq);
    chk("data_req", data_req_o, e_dreq);
    chk("tag_we", tag_we_o, e_twe);
    chk("data_we", data_we_o, e_dwe);
    chk("lookup_ready", lookup_ready_o, e_lr);
    chk("refill_ready", refill_ready_o, e_rr);
    chk("flush_done", flush_done_o, e_done);
    if (!rs) begin
      chk("flush_en", flush_en_o, e_fen);
      chk("valid_bit", valid_bit_o, e_vb);
      chk("tag_o", tag_o, e_tag);
      chk("cline_o", cline_o, e_cl);
      if (e_acc) chk("addr_o", addr_o, e_addr);
    end
    m_pend = n_pend;
    m_hw   = n_hw;
    @(posedge clk_i);
    #1;
    if (!rs) begin
      chk("flush_busy", flush_busy_o, m_sweep >= 0);
      chk("refill_way", refill_way_o, N'(1) << m_rr);
    end
  endtask

  task automatic idle(input int n, input bit lv);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, lv, 5, 'h12345);
  endtask

  initial begin
    rst_i = 1; flush_req_i = 0; refill_valid_i = 0; lookup_valid_i = 0;
    refill_addr_i = '0; refill_tag_i = '0; refill_cline_i = '0;
    lookup_addr_i = '0; lookup_tag_i = '0;
    @(posedge clk_i);
    #1;
    m_sweep = 0; m_rr = 0; m_pend = 0; m_hw = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // reset sweep with a lookup pending throughout
    idle(D + 2, 1);
    cyc(0, 0, 1, 5, 'h12345, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 5, 'h12345);
    cyc(0, 0, 0, 0, 0, 1, 5, 'h12346);
    idle(1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 9, 'h200 + i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 9, 'h204);
    cyc(0, 0, 0, 0, 0, 1, 9, 'h201);
    // collision: flush beats refill beats lookup
    cyc(0, 1, 1, 3, 'h7, 1, 3, 'h7);
    idle(D + 1, 0);
    cyc(0, 0, 1, 5, 'h12345, 1, 5, 'h12345);
    cyc(0, 0, 1, 9, 'h999, 1, 9, 'h999);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(D, 0);
    cyc(0, 0, 0, 0, 0, 1, 5, 'h12345);
    cyc(0, 0, 0, 0, 0, 1, 9, 'h999);
    // reset in the middle of a sweep
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < D && m_sweep != 30; i++) idle(1, 0);
    chk("sweep_at_30", m_sweep, 30);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    idle(D + 3, 1);
    // randomized traffic on a small set/tag pool to force hits
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7),
          'h100 + $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 7), 'h100 + $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
